c2c_ram: RTL

C2C_RAM -- requirements
Module: c2c_ram

---
 rtl/c2c_pkg.sv | 21 ++
 rtl/c2c_r.sv | 10 +
 rtl/c2c_w.sv | 11 +
 rtl/sram_sp.sv | 34 +++
 rtl/c2c_ram.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/c2c_pkg.sv
// Shared definitions for the chip-to-chip RAM responder: bus width, strobe
// width, FSM state encoding and the last-served arbitration flag.
package c2c_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP_R,
        RESP_W
    } c2c_ram_state_e;

    typedef enum logic {
        LAST_READ,
        LAST_WRITE
    } c2c_last_e;

endpackage

// File: rtl/c2c_r.sv
// Read channel of the chip-to-chip bus: master holds addr/re until a one-cycle ack.
interface c2c_r;
    logic [c2c_pkg::XLEN-1:0] addr;
    logic                     re;
    logic [c2c_pkg::XLEN-1:0] rdata;
    logic                     ack;

    modport master (output addr, output re, input rdata, input ack);
    modport slave  (input addr, input re, output rdata, output ack);
endinterface

// File: rtl/c2c_w.sv
// Write channel of the chip-to-chip bus: master holds addr/we/wdata/wstrb until ack.
interface c2c_w;
    logic [c2c_pkg::XLEN-1:0]   addr;
    logic                       we;
    logic [c2c_pkg::XLEN-1:0]   wdata;
    logic [c2c_pkg::STRB_W-1:0] wstrb;
    logic                       ack;

    modport master (output addr, output we, output wdata, output wstrb, input ack);
    modport slave  (input addr, input we, input wdata, input wstrb, output ack);
endinterface

// File: rtl/sram_sp.sv
// Single-port byte-enable RAM with one registered read/write port (read-first).
// One byte-wide array per lane so each lane maps onto its own block RAM column.
module sram_sp #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [WIDTH/8-1:0]       we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH / 8; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we[gi]) begin
                        mem[addr] <= wdata[gi*8 +: 8];
                    end
                    q_reg <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/c2c_ram.sv
// RAM responder for separate c2c read and write channels with alternating
// arbitration. Optional wait states are enabled by defining C2C_RAM_WAIT_EN.
module c2c_ram
    import c2c_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    c2c_r.slave  data_bus_r,
    c2c_w.slave  data_bus_w
);

    localparam int IDX_W = $clog2(DEPTH);

    c2c_ram_state_e    state_reg;
    c2c_last_e         last_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [STRB_W-1:0] wstrb_reg;
    logic [XLEN-1:0]   rdata_reg;
    logic              ack_r_reg;
    logic              ack_w_reg;

    logic              grant_r;
    logic              grant_w;
    logic              wait_done;
    logic              commit_w;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_w;

    logic              ram_en;
    logic [STRB_W-1:0] ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [XLEN-1:0]   ram_rdata;

    assign idx_r = data_bus_r.addr[IDX_W+1:2];
    assign idx_w = data_bus_w.addr[IDX_W+1:2];

    always_comb begin
        grant_r = 1'b0;
        grant_w = 1'b0;
        if (state_reg == IDLE) begin
            if (data_bus_r.re && data_bus_w.we) begin
                grant_w = (last_reg == LAST_READ);
                grant_r = (last_reg == LAST_WRITE);
            end else begin
                grant_r = data_bus_r.re;
                grant_w = data_bus_w.we;
            end
        end
    end

    // The read is issued at grant so the registered RAM output is already
    // stable for the whole READ state, however long the wait lasts.
    assign commit_w = (state_reg == WRITE) && wait_done && !reset;
    assign ram_en   = (grant_r && !reset) || commit_w;
    assign ram_we   = commit_w ? wstrb_reg : '0;
    assign ram_addr = (state_reg == IDLE) ? idx_r : idx_reg;

    sram_sp #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_reg),
        .rdata (ram_rdata)
    );

`ifdef C2C_RAM_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] wait_cnt_reg;

    assign wait_done = (wait_cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if (grant_r || grant_w) begin
            wait_cnt_reg <= CNT_W'(WAIT_CYCLES);
        end else if ((state_reg == READ || state_reg == WRITE) && !wait_done) begin
            wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
        end
    end
`else
    logic [31:0] unused_wait_cycles;

    assign wait_done          = 1'b1;
    assign unused_wait_cycles = WAIT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            last_reg  <= LAST_READ;
            rdata_reg <= '0;
            ack_r_reg <= 1'b0;
            ack_w_reg <= 1'b0;
        end else begin
            ack_r_reg <= 1'b0;
            ack_w_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_w) begin
                        state_reg <= WRITE;
                        last_reg  <= LAST_WRITE;
                    end else if (grant_r) begin
                        state_reg <= READ;
                        last_reg  <= LAST_READ;
                    end
                end
                READ: begin
                    if (wait_done) begin
                        state_reg <= RESP_R;
                        ack_r_reg <= 1'b1;
                        rdata_reg <= ram_rdata;
                    end
                end
                WRITE: begin
                    if (wait_done) begin
                        state_reg <= RESP_W;
                        ack_w_reg <= 1'b1;
                    end
                end
                RESP_R, RESP_W: state_reg <= IDLE;
                default:        state_reg <= IDLE;
            endcase
        end
    end

    // Payload is captured once at grant; later bus changes cannot affect it.
    always_ff @(posedge clk) begin
        if (grant_w) begin
            idx_reg   <= idx_w;
            wdata_reg <= data_bus_w.wdata;
            wstrb_reg <= data_bus_w.wstrb;
        end else if (grant_r) begin
            idx_reg   <= idx_r;
        end
    end

    assign data_bus_r.rdata = rdata_reg;
    assign data_bus_r.ack   = ack_r_reg;
    assign data_bus_w.ack   = ack_w_reg;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_bus_r.addr[XLEN-1:IDX_W+2], data_bus_r.addr[1:0],
                                data_bus_w.addr[XLEN-1:IDX_W+2], data_bus_w.addr[1:0]};

endmodule
